spim_fifo_ctrl: RTL

//  CPU-visible SPI master behind the NORA bus decoder, registers CTRL (0x9F52) and DATA (0x9F53).

---
 rtl/spim_fifo_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spim_fifo_ctrl.sv
// spim_fifo_ctrl
//   CPU-visible SPI master with a CTRL and a DATA register. Bytes written to
//   DATA queue in a TX FIFO and are shifted out in SPI mode 0, MSB first.
//   Each received byte is queued in an RX FIFO, which the CPU drains by
//   reading DATA.
// Ports
//   clk6x     system clock, everything runs on its rising edge
//   rst       asynchronous active-high reset
//   reg_addr  0 = CTRL, 1 = DATA
//   reg_wr    one-cycle write strobe
//   reg_rd    one-cycle read strobe (pops RX when reg_addr = 1)
//   wdata     write data
//   rdata     combinational read data
//   spi_sck   SPI clock, idles low
//   spi_mosi  SPI data out
//   spi_miso  SPI data in
//   spi_csn   active-low chip selects, one per target

// Byte FIFO used for both directions. The flush takes priority over a
// pop but never over a push, so a byte completed in the flush cycle survives.
module spim_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk6x,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_push = push && (!full || flush);
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr_reg];

  always_ff @(posedge clk6x or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (flush) begin
        // Everything queued is dropped; a simultaneous push becomes the only entry.
        rd_ptr_reg <= wr_ptr_reg;
        count_reg  <= {{AW{1'b0}}, do_push};
      end else begin
        if (do_pop)
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
    end
  end

  always_ff @(posedge clk6x) begin
    if (do_push)
      mem[wr_ptr_reg] <= din;
  end
endmodule

module spim_fifo_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int NTARGETS   = 1
) (
  input  logic                clk6x,
  input  logic                rst,
  input  logic                reg_addr,
  input  logic                reg_wr,
  input  logic                reg_rd,
  input  logic [7:0]          wdata,
  output logic [7:0]          rdata,
  output logic                spi_sck,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic [NTARGETS-1:0] spi_csn
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t        state_reg;
  logic [2:0]    target_reg;
  logic [2:0]    speed_reg;
  logic [2:0]    cnt_reg;        // cycles left in the current half-period
  logic [3:0]    bits_reg;       // falling edges still to come
  logic [7:0]    shift_reg;
  logic          sck_reg;
  logic          mosi_reg;
  logic          miso_sample_reg;
  logic [NTARGETS-1:0] csn_reg;

  logic       ctrl_wr;
  logic       data_wr;
  logic       data_rd;
  logic       flush;
  logic       tx_empty;
  logic       rx_empty;
  logic [7:0] tx_head;
  logic [7:0] rx_head;
  logic       tx_pop;
  logic       rx_push;
  logic       busy;
  logic       ctrl_unused;

  assign ctrl_wr     = reg_wr && !reg_addr;
  assign data_wr     = reg_wr && reg_addr;
  assign data_rd     = reg_rd && reg_addr;
  assign flush       = ctrl_wr && wdata[6];
  assign ctrl_unused = wdata[7];

  // The engine takes a new byte from IDLE, or directly from DONE so that
  // back-to-back bytes keep the chip select low with no idle gap.
  assign tx_pop  = ((state_reg == IDLE) || (state_reg == DONE)) && !tx_empty;
  assign rx_push = (state_reg == DONE);
  assign busy    = !tx_empty || (state_reg != IDLE);

  spim_fifo_buf #(.DEPTH(FIFO_DEPTH)) tx_fifo (
    .clk6x (clk6x),
    .rst   (rst),
    .push  (data_wr),
    .pop   (tx_pop),
    .flush (flush),
    .din   (wdata),
    .dout  (tx_head),
    .empty (tx_empty)
  );

  spim_fifo_buf #(.DEPTH(FIFO_DEPTH)) rx_fifo (
    .clk6x (clk6x),
    .rst   (rst),
    .push  (rx_push),
    .pop   (data_rd),
    .flush (flush),
    .din   (shift_reg),
    .dout  (rx_head),
    .empty (rx_empty)
  );

  always_comb begin
    rdata = 8'h00;
    if (reg_addr)
      rdata = rx_empty ? 8'h00 : rx_head;
    else
      rdata = {busy, !rx_empty, speed_reg, target_reg};
  end

  always_ff @(posedge clk6x or posedge rst) begin
    if (rst) begin
      target_reg <= 3'd0;
      speed_reg  <= 3'd0;
    end else if (ctrl_wr) begin
      target_reg <= wdata[2:0];
      speed_reg  <= wdata[5:3];
    end
  end

  // One registered select per target; targets with no matching output
  // simply leave every line high.
  generate
    for (genvar gi = 0; gi < NTARGETS; gi++) begin : g_csn
      always_ff @(posedge clk6x or posedge rst) begin
        if (rst)
          csn_reg[gi] <= 1'b1;
        else if (ctrl_wr)
          csn_reg[gi] <= (wdata[2:0] != 3'(gi + 1));
      end
    end
  endgenerate

  // Half-period length is latched at the start of each half, so a SPEED
  // change lands on the next half-period rather than mid-way.
  always_ff @(posedge clk6x or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= 3'd0;
      bits_reg        <= 4'd0;
      shift_reg       <= 8'h00;
      sck_reg         <= 1'b0;
      mosi_reg        <= 1'b0;
      miso_sample_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (!tx_empty) begin
            shift_reg <= tx_head;
            mosi_reg  <= tx_head[7];
            cnt_reg   <= speed_reg;
            state_reg <= LOAD;
          end else begin
            state_reg <= IDLE;
          end
        end
        LOAD: begin
          if (cnt_reg == 3'd0) begin
            sck_reg         <= 1'b1;
            miso_sample_reg <= spi_miso;
            bits_reg        <= 4'd8;
            cnt_reg         <= speed_reg;
            state_reg       <= SHIFT;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        SHIFT: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else if (sck_reg) begin
            // Falling edge: shift the sampled bit in, present the next bit.
            sck_reg   <= 1'b0;
            shift_reg <= {shift_reg[6:0], miso_sample_reg};
            mosi_reg  <= shift_reg[6];
            bits_reg  <= bits_reg - 4'd1;
            cnt_reg   <= speed_reg;
          end else if (bits_reg == 4'd0) begin
            // Low half after the 8th fall has elapsed.
            state_reg <= DONE;
          end else begin
            sck_reg         <= 1'b1;
            miso_sample_reg <= spi_miso;
            cnt_reg         <= speed_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign spi_sck  = sck_reg;
  assign spi_mosi = mosi_reg;
  assign spi_csn  = csn_reg;
endmodule
